line_buf_ctrl: RTL and testbench

LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

---
 rtl/line_buf_ctrl_if.sv | 33 +++
 rtl/line_buf_ctrl.sv | 137 +++++++++++++
 tb/tb_line_buf_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_buf_ctrl_if.sv
// Video-timing bundle between the sync source and the line-buffer controller.
// The master drives sync/valid; the slave returns RAM control and window status.
interface line_buf_ctrl_if #(
    parameter int AW = 10,
    parameter int HW = 9
);
    logic          vs_in;
    logic          de_in;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic          wr_sel;
    logic          rd_sel;
    logic [AW-1:0] col;
    logic [HW-1:0] row;
    logic          win_valid;
    logic          win_last;
    logic          frame_done;
    logic          resync;
    logic          ovf;
    logic [1:0]    state;

    modport master (
        output vs_in, de_in,
        input  ram_addr, ram_we, wr_sel, rd_sel, col, row,
               win_valid, win_last, frame_done, resync, ovf, state
    );

    modport slave (
        input  vs_in, de_in,
        output ram_addr, ram_we, wr_sel, rd_sel, col, row,
               win_valid, win_last, frame_done, resync, ovf, state
    );
endinterface

// File: rtl/line_buf_ctrl.sv
// Write-side controller for a two-line ping-pong buffer feeding a 3x3 window.
// Tracks column/row from vs/de, steers writes and flags window-valid pixels.
module line_buf_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int AW    = 10,
    parameter int HW    = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    line_buf_ctrl_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [AW-1:0] COL_MAX  = AW'(IMG_W - 1);
    localparam logic [AW-1:0] COL_WIN  = AW'(2);
    localparam logic [HW-1:0] ROW_ONE  = HW'(1);
    localparam logic [HW-1:0] ROW_LAST = HW'(IMG_H - 1);

    state_t        state_reg, state_next;
    logic          vs_d_reg, de_d_reg;
    logic [AW-1:0] col_reg;
    logic [HW-1:0] row_reg;
    logic          wr_sel_reg;
    logic          full_reg;       // last column of this line already written
    logic          win_valid_reg, win_last_reg;
    logic          resync_reg;
    logic          ovf_reg;

    logic vs_rise, de_fall, active, at_max, sat, we, win_cond;

    always_comb begin
        vs_rise  = bus.vs_in & ~vs_d_reg;
        de_fall  = ~bus.de_in & de_d_reg;
        active   = (state_reg == FILL) || (state_reg == RUN);
        at_max   = (col_reg == COL_MAX);
        sat      = bus.de_in & at_max & full_reg;
        we       = bus.de_in & active & ~sat;
        win_cond = bus.de_in & (state_reg == RUN) & (col_reg >= COL_WIN) & ~sat;
    end

    // Frame sequencing; a new vs edge always restarts from FILL.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (vs_rise) state_next = FILL;
            end
            FILL: begin
                if (vs_rise)                              state_next = FILL;
                else if (de_fall && (row_reg == ROW_ONE)) state_next = RUN;
            end
            RUN: begin
                if (vs_rise)                               state_next = FILL;
                else if (de_fall && (row_reg == ROW_LAST)) state_next = DONE;
            end
            DONE: begin
                state_next = vs_rise ? FILL : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d_reg      <= 1'b0;
            de_d_reg      <= 1'b0;
            col_reg       <= '0;
            row_reg       <= '0;
            wr_sel_reg    <= 1'b0;
            full_reg      <= 1'b0;
            win_valid_reg <= 1'b0;
            win_last_reg  <= 1'b0;
            resync_reg    <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            vs_d_reg      <= bus.vs_in;
            de_d_reg      <= bus.de_in;
            resync_reg    <= vs_rise & active;
            win_valid_reg <= win_cond;
            win_last_reg  <= win_cond & at_max;
            if (sat && active) begin
                ovf_reg <= 1'b1;
            end

            if (vs_rise) begin
                col_reg    <= '0;
                row_reg    <= '0;
                wr_sel_reg <= 1'b0;
                full_reg   <= 1'b0;
            end else if (active) begin
                if (de_fall) begin
                    col_reg    <= '0;
                    row_reg    <= row_reg + ROW_ONE;
                    wr_sel_reg <= ~wr_sel_reg;
                    full_reg   <= 1'b0;
                end else if (we) begin
                    // Column saturates at the line end; later pixels are dropped.
                    if (at_max) full_reg <= 1'b1;
                    else        col_reg  <= col_reg + AW'(1);
                end
            end else begin
                col_reg  <= '0;
                full_reg <= 1'b0;
                if (state_reg == IDLE) row_reg <= '0;
            end
        end
    end

    assign bus.ram_addr   = col_reg;
    assign bus.ram_we     = we;
    assign bus.wr_sel     = wr_sel_reg;
    assign bus.rd_sel     = ~wr_sel_reg;
    assign bus.col        = col_reg;
    assign bus.row        = row_reg;
    assign bus.win_valid  = win_valid_reg;
    assign bus.win_last   = win_last_reg;
    assign bus.frame_done = (state_reg == DONE);
    assign bus.resync     = resync_reg;
    assign bus.ovf        = ovf_reg;
    assign bus.state      = state_reg;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Randomized line/frame stimulus for line_buf_ctrl with a line-level reference
// model feeding write/window queues that a negedge monitor drains.
module tb_line_buf_ctrl;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int AW = 10;
    localparam int HW = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    line_buf_ctrl_if #(.AW(AW), .HW(HW)) bus ();

    line_buf_ctrl #(.IMG_W(W), .IMG_H(H), .AW(AW), .HW(HW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {int row; int sel; int addr;} wr_t;
    typedef struct {int row; int last;} win_t;

    wr_t  wr_q[$];
    win_t win_q[$];

    int checks = 0;
    int failures = 0;
    int exp_done = 0, got_done = 0;
    int exp_resync = 0, got_resync = 0;
    bit exp_ovf = 0;
    bit in_frame = 0;
    int mrow = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every write and every window must match the queued expectation.
    wr_t  me;
    win_t mw;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.ram_we) begin
                    if (wr_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_write: addr %0d row %0d at %0t", bus.ram_addr, bus.row, $time);
                    end else begin
                        me = wr_q.pop_front();
                        check("wr_row",  int'(bus.row), me.row);
                        check("wr_addr", int'(bus.ram_addr), me.addr);
                        check("wr_sel",  int'(bus.wr_sel), me.sel);
                        check("rd_sel",  int'(bus.rd_sel), 1 - me.sel);
                        $display("write row=%0d addr=%0d sel=%0d", bus.row, bus.ram_addr, bus.wr_sel);
                    end
                end
                if (bus.win_valid) begin
                    if (win_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_window: row %0d at %0t", bus.row, $time);
                    end else begin
                        mw = win_q.pop_front();
                        check("win_row",  int'(bus.row), mw.row);
                        check("win_last", int'(bus.win_last), mw.last);
                    end
                end else if (bus.win_last) begin
                    checks++; failures++;
                    $display("FAIL win_last_alone: got 1 expected 0 at %0t", $time);
                end
                if (bus.frame_done) got_done++;
                if (bus.resync)     got_resync++;
            end
        end
    end

    initial begin
        #2_000_000;
        checks++; failures++;
        $display("FAIL timeout: simulation exceeded time budget");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic cyc(input bit vs, input bit de);
        @(posedge clk);
        #1;
        bus.vs_in = vs;
        bus.de_in = de;
    endtask

    task automatic push_pixels(input int n);
        wr_t  w;
        win_t v;
        for (int c = 0; c < n; c++) begin
            w.row = mrow; w.sel = mrow % 2; w.addr = c;
            wr_q.push_back(w);
        end
        if (mrow >= 2) begin
            for (int c = 2; c < n; c++) begin
                v.row = mrow; v.last = (c == W - 1) ? 1 : 0;
                win_q.push_back(v);
            end
        end
    endtask

    task automatic line(input int len, input int gap);
        int n;
        n = (len < W) ? len : W;
        if (in_frame) begin
            push_pixels(n);
            if (len > W) exp_ovf = 1;
        end
        for (int i = 0; i < len; i++) begin
            cyc(0, 1);
            if (i == 0) check("line_state", int'(bus.state), in_frame ? ((mrow >= 2) ? 2 : 1) : 0);
        end
        for (int i = 0; i < gap; i++) cyc(0, 0);
        if (in_frame) begin
            mrow++;
            if (mrow == H) begin
                exp_done++;
                in_frame = 0;
            end
        end
    endtask

    task automatic start_frame();
        if (in_frame) exp_resync++;
        in_frame = 1;
        mrow = 0;
        cyc(1, 0);
        cyc(0, 0);
    endtask

    // k pixels of the current line, then vs rises as de drops.
    task automatic abort_line(input int k);
        push_pixels(k);
        for (int i = 0; i < k; i++) cyc(0, 1);
        cyc(1, 0);
        @(posedge clk);
        #1;
        check("abort_state",  int'(bus.state), 1);
        check("abort_row",    int'(bus.row), 0);
        check("abort_col",    int'(bus.col), 0);
        check("abort_wr_sel", int'(bus.wr_sel), 0);
        check("abort_resync", int'(bus.resync), 1);
        check("abort_done",   int'(bus.frame_done), 0);
        bus.vs_in = 0;
        exp_resync++;
        mrow = 0;
        in_frame = 1;
        cyc(0, 0);
    endtask

    task automatic reset_mid(input int k);
        push_pixels(k);
        for (int i = 0; i < k; i++) cyc(0, 1);
        @(posedge clk);
        #1;
        bus.de_in = 0;
        @(negedge clk);
        #2;
        rst = 1;
        #1;
        check("rst_state",     int'(bus.state), 0);
        check("rst_col",       int'(bus.col), 0);
        check("rst_row",       int'(bus.row), 0);
        check("rst_addr",      int'(bus.ram_addr), 0);
        check("rst_we",        int'(bus.ram_we), 0);
        check("rst_wr_sel",    int'(bus.wr_sel), 0);
        check("rst_rd_sel",    int'(bus.rd_sel), 1);
        check("rst_win_valid", int'(bus.win_valid), 0);
        check("rst_win_last",  int'(bus.win_last), 0);
        check("rst_done",      int'(bus.frame_done), 0);
        check("rst_resync",    int'(bus.resync), 0);
        check("rst_ovf",       int'(bus.ovf), 0);
        exp_ovf = 0;
        in_frame = 0;
        mrow = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        int guard;
        rst = 1;
        bus.vs_in = 0;
        bus.de_in = 0;
        repeat (3) @(posedge clk);
        #1;
        check("init_state",     int'(bus.state), 0);
        check("init_col",       int'(bus.col), 0);
        check("init_row",       int'(bus.row), 0);
        check("init_we",        int'(bus.ram_we), 0);
        check("init_win_valid", int'(bus.win_valid), 0);
        check("init_ovf",       int'(bus.ovf), 0);
        rst = 0;

        // de activity before any frame sync is ignored
        line(5, 2);
        line(8, 1);
        check("pre_state", int'(bus.state), 0);
        check("pre_col",   int'(bus.col), 0);
        check("pre_row",   int'(bus.row), 0);
        $display("pre-frame de bursts done");

        start_frame();
        for (int r = 0; r < H; r++) line(W, $urandom_range(1, 3));
        repeat (3) cyc(0, 0);
        check("frame1_idle", int'(bus.state), 0);
        check("frame1_ovf",  int'(bus.ovf), 0);
        $display("nominal frame done");

        start_frame();
        line(W + 2, 2);
        check("ovf_set", int'(bus.ovf), 1);
        for (int r = 1; r < H; r++) line($urandom_range(3, W), $urandom_range(1, 3));
        repeat (3) cyc(0, 0);
        check("ovf_sticky", int'(bus.ovf), int'(exp_ovf));
        $display("overflow frame done");

        start_frame();
        line(W, 2);
        line(W, 2);
        abort_line(3);
        for (int r = 0; r < H; r++) line(W, 2);
        $display("resync frame done");

        for (int f = 0; f < 6; f++) begin
            start_frame();
            guard = 0;
            while (in_frame) begin
                guard++;
                if (guard < 20 && $urandom_range(0, 7) == 0)
                    abort_line($urandom_range(1, W));
                else
                    line($urandom_range(3, W + 2), $urandom_range(1, 3));
            end
            $display("random frame %0d done", f);
        end

        start_frame();
        for (int r = 0; r < H - 1; r++) line(W, 2);
        reset_mid(5);
        line(W, 2);
        line(W, 2);
        check("post_rst_state", int'(bus.state), 0);
        check("post_rst_row",   int'(bus.row), 0);
        $display("mid-frame reset done");

        repeat (5) cyc(0, 0);
        check("wr_q_empty",  wr_q.size(), 0);
        check("win_q_empty", win_q.size(), 0);
        check("done_count",  got_done, exp_done);
        check("resync_count", got_resync, exp_resync);
        check("final_ovf",   int'(bus.ovf), int'(exp_ovf));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
